// File: rtl/front_panel_pkg.sv
// Shared types for the front-panel sequencer:
// FSM states, panel operations and button priority.
package front_panel_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WR,
    RD,
    RD_WAIT
  } state_t;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_EX,
    OP_EXN,
    OP_DEP,
    OP_DEPN
  } op_t;

  // Highest-priority button wins; the rest are dropped.
  function automatic op_t pick_op(
    input logic ex,
    input logic exn,
    input logic dep,
    input logic depn
  );
    if (ex) return OP_EX;
    if (exn) return OP_EXN;
    if (dep) return OP_DEP;
    if (depn) return OP_DEPN;
    return OP_NONE;
  endfunction

endpackage

// File: rtl/panel_pb_cond.sv
// Push-button conditioner: synchroniser, debounce,
// press-edge event and optional auto-repeat.
module panel_pb_cond #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_PERIOD = 2500000,
  parameter bit REPEAT_EN = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic pb,
  input  logic en,
  output logic evt
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                        REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = $clog2(RMAX + 1);

  logic [1:0] sync;
  logic raw;
  logic armed;
  logic level;
  logic first;
  logic [DW-1:0] dcnt;
  logic [RW-1:0] rcnt;
  logic [RW-1:0] target;
  logic settle;
  logic rise;

  assign raw = sync[1];
  assign settle = (dcnt == DW'(DEBOUNCE_CYCLES - 1));
  assign rise = armed & ~level & raw & settle;
  assign target = first ? RW'(REPEAT_DELAY) : RW'(REPEAT_PERIOD);

  // Sync resets to 1 so a button held through reset stays unarmed
  // until it has been seen released.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= '1;
      armed <= 1'b0;
      level <= 1'b0;
      first <= 1'b0;
      dcnt <= '0;
      rcnt <= '0;
      evt <= 1'b0;
    end else begin
      sync <= {sync[0], pb};
      evt <= 1'b0;
      if (!raw) armed <= 1'b1;
      if (!armed || raw == level) begin
        dcnt <= '0;
      end else if (settle) begin
        dcnt <= '0;
        level <= raw;
      end else begin
        dcnt <= dcnt + 1'b1;
      end
      if (rise) begin
        evt <= en;
        rcnt <= RW'(1);
        first <= 1'b1;
      end else if (REPEAT_EN && level) begin
        if (rcnt == target) begin
          evt <= en;
          rcnt <= RW'(1);
          first <= 1'b0;
        end else begin
          rcnt <= rcnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/front_panel_seq.sv
// Altair front-panel sequencer: one address register and one FSM
// driving examine/deposit accesses over the panel memory bus.
module front_panel_seq #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_PERIOD = 2500000,
  parameter int RD_LATENCY = 1,
  parameter logic [ADDR_WIDTH-1:0] PROT_BASE = 16'hFD00,
  parameter logic [ADDR_WIDTH-1:0] PROT_MASK = 16'hFF00
) (
  input  logic clk,
  input  logic reset,
  input  logic pause,
  input  logic examine_pb,
  input  logic examine_next_pb,
  input  logic deposit_pb,
  input  logic deposit_next_pb,
  input  logic [ADDR_WIDTH-1:0] sw,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic mem_we,
  output logic mem_re,
  output logic panel_bus,
  output logic cpu_hold,
  output logic busy,
  output logic [ADDR_WIDTH-1:0] addr_leds,
  output logic [DATA_WIDTH-1:0] data_leds,
  output logic prot_err
);
  import front_panel_pkg::*;

  localparam int LW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  logic ev_ex;
  logic ev_exn;
  logic ev_dep;
  logic ev_depn;
  op_t op;
  state_t state, state_nx;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_nx;
  logic [DATA_WIDTH-1:0] data_reg, data_nx;
  logic [LW-1:0] wcnt, wcnt_nx;
  logic prot_hit;

  panel_pb_cond #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD),
    .REPEAT_EN(1'b0)
  ) u_ex (
    .clk(clk), .reset(reset), .pb(examine_pb),
    .en(pause), .evt(ev_ex)
  );

  panel_pb_cond #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD),
    .REPEAT_EN(1'b1)
  ) u_exn (
    .clk(clk), .reset(reset), .pb(examine_next_pb),
    .en(pause), .evt(ev_exn)
  );

  panel_pb_cond #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD),
    .REPEAT_EN(1'b0)
  ) u_dep (
    .clk(clk), .reset(reset), .pb(deposit_pb),
    .en(pause), .evt(ev_dep)
  );

  panel_pb_cond #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD),
    .REPEAT_EN(1'b1)
  ) u_depn (
    .clk(clk), .reset(reset), .pb(deposit_next_pb),
    .en(pause), .evt(ev_depn)
  );

  assign op = pick_op(ev_ex, ev_exn, ev_dep, ev_depn);
  assign prot_hit = ((addr_reg & PROT_MASK) == (PROT_BASE & PROT_MASK));

  assign busy = (state != IDLE);
  assign panel_bus = pause | busy;
  assign cpu_hold = pause | busy;
  assign mem_addr = addr_reg;
  assign addr_leds = addr_reg;
  assign data_leds = data_reg;
  assign mem_wdata = sw[DATA_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      addr_reg <= '0;
      data_reg <= '0;
      wcnt <= '0;
    end else begin
      state <= state_nx;
      addr_reg <= addr_nx;
      data_reg <= data_nx;
      wcnt <= wcnt_nx;
    end
  end

  // Strobes are masked by reset so an aborted op issues nothing.
  always_comb begin
    state_nx = state;
    addr_nx = addr_reg;
    data_nx = data_reg;
    wcnt_nx = wcnt;
    mem_we = 1'b0;
    mem_re = 1'b0;
    prot_err = 1'b0;
    unique case (state)
      IDLE: begin
        if (pause) begin
          unique case (op)
            OP_EX: begin
              addr_nx = sw;
              state_nx = RD;
            end
            OP_EXN: begin
              addr_nx = addr_reg + 1'b1;
              state_nx = RD;
            end
            OP_DEP: state_nx = WR;
            OP_DEPN: begin
              addr_nx = addr_reg + 1'b1;
              state_nx = WR;
            end
            default: ;
          endcase
        end
      end
      WR: begin
        prot_err = prot_hit & ~reset;
        mem_we = ~prot_hit & ~reset;
        state_nx = RD;
      end
      RD: begin
        mem_re = ~reset;
        wcnt_nx = '0;
        state_nx = RD_WAIT;
      end
      RD_WAIT: begin
        if (wcnt == LW'(RD_LATENCY - 1)) begin
          data_nx = mem_rdata;
          state_nx = IDLE;
        end else begin
          wcnt_nx = wcnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_front_panel_seq.sv
// Directed bench for front_panel_seq with a one-cycle
// synchronous-read memory model.
module tb_front_panel_seq;

  logic clk;
  logic reset;
  logic pause;
  logic examine_pb;
  logic examine_next_pb;
  logic deposit_pb;
  logic deposit_next_pb;
  logic [15:0] sw;
  logic [7:0] mem_rdata;
  logic [15:0] mem_addr;
  logic [7:0] mem_wdata;
  logic mem_we;
  logic mem_re;
  logic panel_bus;
  logic cpu_hold;
  logic busy;
  logic [15:0] addr_leds;
  logic [7:0] data_leds;
  logic prot_err;

  logic [7:0] mem [0:65535];
  int total;
  int bad;
  int n_we, n_re, n_prot;
  int b_we, b_re, b_prot;
  bit found;

  front_panel_seq #(
    .ADDR_WIDTH(16),
    .DATA_WIDTH(8),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY(20),
    .REPEAT_PERIOD(8),
    .RD_LATENCY(1),
    .PROT_BASE(16'hFD00),
    .PROT_MASK(16'hFF00)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pause(pause),
    .examine_pb(examine_pb),
    .examine_next_pb(examine_next_pb),
    .deposit_pb(deposit_pb),
    .deposit_next_pb(deposit_next_pb),
    .sw(sw),
    .mem_rdata(mem_rdata),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we(mem_we),
    .mem_re(mem_re),
    .panel_bus(panel_bus),
    .cpu_hold(cpu_hold),
    .busy(busy),
    .addr_leds(addr_leds),
    .data_leds(data_leds),
    .prot_err(prot_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0000] = 8'h5A;
    mem[16'h0100] = 8'h3E;
    mem[16'h0101] = 8'hC3;
  end

  initial begin
    n_we = 0;
    n_re = 0;
    n_prot = 0;
    mem_rdata = 8'h00;
  end

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      n_we++;
    end
    if (mem_re) begin
      mem_rdata <= mem[mem_addr];
      n_re++;
    end
    if (prot_err) n_prot++;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_we = n_we;
    b_re = n_re;
    b_prot = n_prot;
  endtask

  task automatic press(input logic [3:0] m, input int hold);
    {examine_pb, examine_next_pb, deposit_pb, deposit_next_pb} = m;
    step(hold);
    {examine_pb, examine_next_pb, deposit_pb, deposit_next_pb} = 4'b0;
    step(15);
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b1;
    pause = 1'b1;
    sw = 16'h0000;
    examine_pb = 1'b0;
    examine_next_pb = 1'b0;
    deposit_pb = 1'b1;
    deposit_next_pb = 1'b0;
    step(3);

    chk("rst_addr", 32'(addr_leds), 32'h0);
    chk("rst_data", 32'(data_leds), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_we", 32'(mem_we), 32'h0);
    chk("rst_re", 32'(mem_re), 32'h0);
    chk("rst_prot", 32'(prot_err), 32'h0);

    // deposit held through reset must not fire
    reset = 1'b0;
    snap();
    step(10);
    deposit_pb = 1'b0;
    step(15);
    chk("held_rst_we", 32'(n_we - b_we), 32'h0);
    chk("held_rst_re", 32'(n_re - b_re), 32'h0);

    // examine
    sw = 16'h0100;
    snap();
    press(4'b1000, 10);
    chk("ex_re", 32'(n_re - b_re), 32'd1);
    chk("ex_we", 32'(n_we - b_we), 32'd0);
    chk("ex_addr", 32'(addr_leds), 32'h0100);
    chk("ex_data", 32'(data_leds), 32'h3E);
    chk("ex_busy", 32'(busy), 32'h0);

    // examine-next with auto-repeat
    snap();
    examine_next_pb = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      step(1);
      if (addr_leds == 16'h0101) found = 1'b1;
    end
    chk("exn_accept", 32'(found), 32'd1);
    step(2);
    chk("exn_data", 32'(data_leds), 32'hC3);
    step(17);
    chk("exn_pre_rep1", 32'(addr_leds), 32'h0101);
    step(1);
    chk("exn_rep1", 32'(addr_leds), 32'h0102);
    step(7);
    chk("exn_pre_rep2", 32'(addr_leds), 32'h0102);
    examine_next_pb = 1'b0;
    step(1);
    chk("exn_rep2", 32'(addr_leds), 32'h0103);
    step(20);
    chk("exn_final", 32'(addr_leds), 32'h0103);
    chk("exn_reads", 32'(n_re - b_re), 32'd3);

    // deposit-next into protected page
    sw = 16'hFCFF;
    press(4'b1000, 10);
    sw = 16'h00AA;
    snap();
    press(4'b0001, 10);
    chk("prot_addr", 32'(mem_addr), 32'hFD00);
    chk("prot_we", 32'(n_we - b_we), 32'd0);
    chk("prot_pulse", 32'(n_prot - b_prot), 32'd1);
    chk("prot_re", 32'(n_re - b_re), 32'd1);
    chk("prot_data", 32'(data_leds), 32'h00);

    // deposit-next into ordinary memory
    sw = 16'h01FF;
    press(4'b1000, 10);
    sw = 16'h00AA;
    snap();
    press(4'b0001, 10);
    chk("depn_addr", 32'(addr_leds), 32'h0200);
    chk("depn_we", 32'(n_we - b_we), 32'd1);
    chk("depn_prot", 32'(n_prot - b_prot), 32'd0);
    chk("depn_mem", 32'(mem[16'h0200]), 32'hAA);
    chk("depn_data", 32'(data_leds), 32'hAA);

    // wrap plus priority: examine-next beats deposit
    sw = 16'hFFFF;
    press(4'b1000, 10);
    snap();
    press(4'b0110, 10);
    chk("wrap_addr", 32'(addr_leds), 32'h0000);
    chk("wrap_we", 32'(n_we - b_we), 32'd0);
    chk("wrap_re", 32'(n_re - b_re), 32'd1);
    chk("wrap_data", 32'(data_leds), 32'h5A);

    // run mode: buttons ignored, leds hold
    pause = 1'b0;
    sw = 16'h0100;
    snap();
    press(4'b1010, 10);
    chk("run_re", 32'(n_re - b_re), 32'd0);
    chk("run_we", 32'(n_we - b_we), 32'd0);
    chk("run_bus", 32'(panel_bus), 32'd0);
    chk("run_hold", 32'(cpu_hold), 32'd0);
    chk("run_addr", 32'(addr_leds), 32'h0000);
    chk("run_data", 32'(data_leds), 32'h5A);

    // pause drops while in WR
    pause = 1'b1;
    sw = 16'h0010;
    snap();
    deposit_pb = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1);
      if (mem_we) found = 1'b1;
    end
    chk("drop_wr_seen", 32'(found), 32'd1);
    pause = 1'b0;
    chk("drop_hold_wr", 32'(cpu_hold), 32'd1);
    chk("drop_bus_wr", 32'(panel_bus), 32'd1);
    step(1);
    chk("drop_rd_re", 32'(mem_re), 32'd1);
    step(1);
    chk("drop_wait_hold", 32'(cpu_hold), 32'd1);
    step(1);
    chk("drop_idle_busy", 32'(busy), 32'd0);
    chk("drop_idle_hold", 32'(cpu_hold), 32'd0);
    chk("drop_data", 32'(data_leds), 32'h10);
    deposit_pb = 1'b0;
    step(15);
    chk("drop_we_cnt", 32'(n_we - b_we), 32'd1);

    // reset during RD_WAIT
    pause = 1'b1;
    sw = 16'h0100;
    examine_pb = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1);
      if (mem_re) found = 1'b1;
    end
    chk("abort_rd_seen", 32'(found), 32'd1);
    step(1);
    chk("abort_wait_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    step(1);
    chk("abort_addr", 32'(addr_leds), 32'h0);
    chk("abort_data", 32'(data_leds), 32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_re", 32'(mem_re), 32'h0);
    chk("abort_we", 32'(mem_we), 32'h0);
    chk("abort_prot", 32'(prot_err), 32'h0);
    reset = 1'b0;
    examine_pb = 1'b0;
    step(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
